pll_mgmt_responder: RTL

PLL_MGMT_RESPONDER -- requirements
Module: pll_mgmt_responder

---
 rtl/pll_mgmt_pkg.sv | 30 +++
 rtl/pll_mgmt_responder_if.sv | 24 ++
 rtl/sync2.sv | 28 ++
 rtl/pll_mgmt_responder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pll_mgmt_pkg.sv
// Shared definitions for the PLL management responder: register map,
// FSM state encoding and parameter defaults.
package pll_mgmt_pkg;

  // Register map (word addresses on the 6-bit management bus)
  localparam logic [5:0] ADDR_MODE   = 6'd0;
  localparam logic [5:0] ADDR_STATUS = 6'd1;
  localparam logic [5:0] ADDR_START  = 6'd2;
  localparam logic [5:0] ADDR_N      = 6'd3;
  localparam logic [5:0] ADDR_M      = 6'd4;
  localparam logic [5:0] ADDR_C0     = 6'd5;
  localparam logic [5:0] ADDR_MFRAC  = 6'd7;

  // Parameter defaults
  localparam int unsigned RST_CYCLES_DEF   = 16;
  localparam int unsigned LOCK_TIMEOUT_DEF = 4095;

  // Width of the lock-wait timeout counter
  localparam int unsigned TMO_W = 12;

  // Reconfiguration sequencer states
  typedef enum logic [2:0] {
    IDLE,
    RST,
    LOAD,
    REL,
    WLOCK
  } pll_state_e;

endpackage

// File: rtl/pll_mgmt_responder_if.sv
// Management bus of the PLL reconfiguration responder.
//   mgmt_address     : register select
//   mgmt_write/read  : request strobes
//   mgmt_writedata   : write data
//   mgmt_readdata    : read data (combinational, 0 when no read)
//   mgmt_waitrequest : stall for the current request
interface pll_mgmt_responder_if;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic        mgmt_read;
  logic [31:0] mgmt_writedata;
  logic [31:0] mgmt_readdata;
  logic        mgmt_waitrequest;

  modport master (
    output mgmt_address, mgmt_write, mgmt_read, mgmt_writedata,
    input  mgmt_readdata, mgmt_waitrequest
  );

  modport slave (
    input  mgmt_address, mgmt_write, mgmt_read, mgmt_writedata,
    output mgmt_readdata, mgmt_waitrequest
  );
endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk_i : destination clock
//   rst_i : asynchronous active-high reset, clears both stages
//   d_i   : asynchronous input
//   q_o   : synchronized output (two cycles of latency)
module sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_mgmt_responder.sv
// PLL reconfiguration responder. Holds shadow copies of the PLL counter
// settings, and on a START write runs the sequence
//   IDLE -> RST (pll_rst high) -> LOAD (cfg_load strobe) -> REL -> WLOCK
// returning to IDLE on lock or on timeout (which sets a sticky error).
// Ports:
//   mgmt_clk, mgmt_reset : clock, asynchronous active-high reset
//   mgmt                 : management bus (slave side)
//   pll_locked           : asynchronous lock flag from the PLL
//   pll_rst              : PLL reset
//   cfg_load             : one-cycle strobe, cfg_* valid during it
//   cfg_n/m/c0/mfrac     : applied counter values
//   cfg_busy             : sequence in progress
module pll_mgmt_responder
  import pll_mgmt_pkg::*;
#(
  parameter int unsigned RST_CYCLES   = RST_CYCLES_DEF,
  parameter int unsigned LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
  input  logic                    mgmt_clk,
  input  logic                    mgmt_reset,
  pll_mgmt_responder_if.slave     mgmt,
  input  logic                    pll_locked,
  output logic                    pll_rst,
  output logic                    cfg_load,
  output logic [31:0]             cfg_n,
  output logic [31:0]             cfg_m,
  output logic [31:0]             cfg_c0,
  output logic [31:0]             cfg_mfrac,
  output logic                    cfg_busy
);

  localparam int unsigned RCW =
    ($clog2(RST_CYCLES + 1) > 5) ? $clog2(RST_CYCLES + 1) : 5;
  localparam logic [RCW-1:0]   RST_LAST = RCW'(RST_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);

  pll_state_e       state_q, state_d;
  logic [RCW-1:0]   rcnt_q, rcnt_d;
  logic [TMO_W-1:0] tcnt_q, tcnt_d;
  logic             err_q, err_d;
  logic             pll_rst_q, pll_rst_d;
  logic             cfg_load_q, cfg_load_d;
  logic             mode_q, mode_d;
  logic [31:0]      n_q, n_d, m_q, m_d, c0_q, c0_d, mfrac_q, mfrac_d;
  logic [31:0]      cfg_n_q, cfg_n_d, cfg_m_q, cfg_m_d;
  logic [31:0]      cfg_c0_q, cfg_c0_d, cfg_mfrac_q, cfg_mfrac_d;

  logic        lock_s;
  logic        busy;
  logic        wait_req;
  logic        wr_acc;
  logic        wr_cfg_ok;
  logic [31:0] rdata;

  sync2 u_lock_sync (
    .clk_i (mgmt_clk),
    .rst_i (mgmt_reset),
    .d_i   (pll_locked),
    .q_o   (lock_s)
  );

  assign busy = (state_q != IDLE);

  // Waitrequest mode stalls every request while busy; polling never stalls.
  assign wait_req  = ~mgmt_reset & ~mode_q & busy &
                     (mgmt.mgmt_write | mgmt.mgmt_read);
  assign wr_acc    = mgmt.mgmt_write & ~wait_req;
  // Shadow registers and START only take writes while idle; in polling
  // mode this silently drops them during a sequence.
  assign wr_cfg_ok = wr_acc & ~busy;

  always_comb begin
    rdata = '0;
    if (mgmt.mgmt_read && !mgmt_reset) begin
      case (mgmt.mgmt_address)
        ADDR_MODE:   rdata = {31'd0, mode_q};
        ADDR_STATUS: rdata = {30'd0, err_q, busy};
        ADDR_N:      rdata = n_q;
        ADDR_M:      rdata = m_q;
        ADDR_C0:     rdata = c0_q;
        ADDR_MFRAC:  rdata = mfrac_q;
        default:     rdata = '0;
      endcase
    end
  end

  assign mgmt.mgmt_readdata    = rdata;
  assign mgmt.mgmt_waitrequest = wait_req;

  always_comb begin
    state_d     = state_q;
    rcnt_d      = rcnt_q;
    tcnt_d      = tcnt_q;
    err_d       = err_q;
    mode_d      = mode_q;
    n_d         = n_q;
    m_d         = m_q;
    c0_d        = c0_q;
    mfrac_d     = mfrac_q;
    cfg_n_d     = cfg_n_q;
    cfg_m_d     = cfg_m_q;
    cfg_c0_d    = cfg_c0_q;
    cfg_mfrac_d = cfg_mfrac_q;
    cfg_load_d  = 1'b0;
    // pll_rst is registered off the RST state: it rises one cycle into RST
    // and falls on entry to REL, so it is high for RST_CYCLES cycles that
    // include the LOAD cycle.
    pll_rst_d   = (state_q == RST);

    if (wr_acc && mgmt.mgmt_address == ADDR_MODE) begin
      mode_d = mgmt.mgmt_writedata[0];
    end

    if (wr_cfg_ok) begin
      case (mgmt.mgmt_address)
        ADDR_N:     n_d     = mgmt.mgmt_writedata;
        ADDR_M:     m_d     = mgmt.mgmt_writedata;
        ADDR_C0:    c0_d    = mgmt.mgmt_writedata;
        ADDR_MFRAC: mfrac_d = mgmt.mgmt_writedata;
        default:    ;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (wr_cfg_ok && mgmt.mgmt_address == ADDR_START) begin
          state_d = RST;
          rcnt_d  = '0;
        end
      end
      RST: begin
        if (rcnt_q >= RST_LAST) begin
          // cfg_* are captured on the edge into LOAD so they are already
          // valid while the cfg_load strobe is high.
          state_d     = LOAD;
          cfg_load_d  = 1'b1;
          cfg_n_d     = n_q;
          cfg_m_d     = m_q;
          cfg_c0_d    = c0_q;
          cfg_mfrac_d = mfrac_q;
        end else begin
          rcnt_d = rcnt_q + RCW'(1);
        end
      end
      LOAD: begin
        state_d = REL;
      end
      REL: begin
        tcnt_d  = '0;
        state_d = WLOCK;
      end
      WLOCK: begin
        if (lock_s) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end else if (tcnt_q >= TMO_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TMO_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge mgmt_clk or posedge mgmt_reset) begin
    if (mgmt_reset) begin
      state_q     <= IDLE;
      rcnt_q      <= '0;
      tcnt_q      <= '0;
      err_q       <= 1'b0;
      pll_rst_q   <= 1'b0;
      cfg_load_q  <= 1'b0;
      mode_q      <= 1'b0;
      n_q         <= '0;
      m_q         <= '0;
      c0_q        <= '0;
      mfrac_q     <= '0;
      cfg_n_q     <= '0;
      cfg_m_q     <= '0;
      cfg_c0_q    <= '0;
      cfg_mfrac_q <= '0;
    end else begin
      state_q     <= state_d;
      rcnt_q      <= rcnt_d;
      tcnt_q      <= tcnt_d;
      err_q       <= err_d;
      pll_rst_q   <= pll_rst_d;
      cfg_load_q  <= cfg_load_d;
      mode_q      <= mode_d;
      n_q         <= n_d;
      m_q         <= m_d;
      c0_q        <= c0_d;
      mfrac_q     <= mfrac_d;
      cfg_n_q     <= cfg_n_d;
      cfg_m_q     <= cfg_m_d;
      cfg_c0_q    <= cfg_c0_d;
      cfg_mfrac_q <= cfg_mfrac_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign cfg_load  = cfg_load_q;
  assign cfg_n     = cfg_n_q;
  assign cfg_m     = cfg_m_q;
  assign cfg_c0    = cfg_c0_q;
  assign cfg_mfrac = cfg_mfrac_q;
  assign cfg_busy  = busy;

endmodule
